// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One transaction in flight; data wins unless fetch has been starved too long.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  input  logic        i_cancel,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  starve_cnt;
  logic        cancel_flag;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        d_req;
  logic        grant_d;
  logic        grant_i;
  logic        done;

  assign d_req = d_read | d_write;

  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_read || starve_cnt < LIMIT)) begin
          grant_d  = 1'b1;
          state_nx = D_BUSY;
        end else if (i_read && !i_cancel) begin
          grant_i  = 1'b1;
          state_nx = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A squashed fetch still finishes on the bus but is never reported.
  assign i_resp = !rst && (state == I_BUSY) && mem_resp
                  && !cancel_flag && !i_cancel;
  assign d_resp = !rst && (state == D_BUSY) && mem_resp;

  assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      starve_cnt  <= '0;
      cancel_flag <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_read  <= !d_write;
        mem_write <= d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wmask <= d_wmask;
      end else if (grant_i) begin
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end else if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end

      if (i_resp) i_rdata_q <= mem_rdata;
      if (d_resp) d_rdata_q <= mem_rdata;

      if (done) begin
        cancel_flag <= 1'b0;
      end else if (state == I_BUSY && i_cancel) begin
        cancel_flag <= 1'b1;
      end

      // Count only data grants that overtook a live fetch request.
      if (state == IDLE) begin
        if (grant_i || !i_read) begin
          starve_cnt <= '0;
        end else if (grant_d && !i_cancel && starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_cancel;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'hc3c3};
  endfunction

  // Memory: responds once the strobe has been high for more than lat cycles.
  int lat = 3;
  int mcnt = 0;
  bit spur_en = 0;
  always @(posedge clk) begin
    #1;
    mem_resp = 1'b0;
    if (mem_read || mem_write) begin
      mcnt++;
      if (mcnt > lat) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_data(mem_addr);
        mcnt = 0;
        if (spur_en) lat = $urandom_range(0, 3);
      end
    end else begin
      mcnt = 0;
      if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_resp  = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: grant log and response pulse counts.
  logic [31:0] g_addr[$];
  int          g_cyc[$];
  bit          prev_act = 0;
  int          ir_cnt = 0;
  int          dr_cnt = 0;
  always @(negedge clk) begin
    if ((mem_read || mem_write) && !prev_act) begin
      g_addr.push_back(mem_addr);
      g_cyc.push_back(cyc);
    end
    prev_act = mem_read || mem_write;
    if (i_resp) ir_cnt++;
    if (d_resp) dr_cnt++;
  end

  // Reference model: one owner at a time, transaction captured at grant.
  bit          mon = 0;
  bit          m_busy = 0;
  bit          m_fetch = 0;
  bit          m_cxl = 0;
  bit          m_write = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wmask = '0;
  int          m_starve = 0;
  logic [31:0] m_ird = '0;
  logic [31:0] m_drd = '0;

  always @(negedge clk) begin
    if (mon) begin
      logic e_ir;
      logic e_dr;
      e_ir = !rst && m_busy && m_fetch && mem_resp && !m_cxl && !i_cancel;
      e_dr = !rst && m_busy && !m_fetch && mem_resp;
      chk("i_resp", 32'(i_resp), 32'(e_ir));
      chk("d_resp", 32'(d_resp), 32'(e_dr));
      chk("i_rdata", i_rdata, e_ir ? mem_rdata : m_ird);
      chk("d_rdata", d_rdata, e_dr ? mem_rdata : m_drd);
      chk("mem_read", 32'(mem_read), 32'(m_busy && !m_write));
      chk("mem_write", 32'(mem_write), 32'(m_busy && m_write));
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_fetch) chk("mem_wmask_fetch", 32'(mem_wmask), 32'd0);
        if (m_write) begin
          chk("mem_wdata", mem_wdata, m_wdata);
          chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
        end
      end
      if (rst) begin
        m_busy = 0; m_cxl = 0; m_starve = 0;
        m_ird = '0; m_drd = '0;
      end else if (m_busy) begin
        if (e_ir) m_ird = mem_rdata;
        if (e_dr) m_drd = mem_rdata;
        if (m_fetch && i_cancel) m_cxl = 1;
        if (mem_resp) begin
          m_busy = 0;
          m_cxl = 0;
        end
      end else if ((d_read || d_write) && (!i_read || m_starve < LIMIT)) begin
        m_busy = 1; m_fetch = 0; m_write = d_write;
        m_addr = d_addr; m_wdata = d_wdata; m_wmask = d_wmask;
        if (!i_read) m_starve = 0;
        else if (!i_cancel && m_starve < 15) m_starve++;
      end else if (i_read && !i_cancel) begin
        m_busy = 1; m_fetch = 1; m_write = 0;
        m_addr = i_addr; m_starve = 0;
      end else if (!i_read) begin
        m_starve = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return i_resp;
      1: return d_resp;
      2: return mem_read;
      3: return mem_write;
      default: return !(mem_read || mem_write);
    endcase
  endfunction

  task automatic wait_sig(input int w, input int maxc, input string nm,
                          output int n);
    n = 0;
    while (!sig(w) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sig(w)), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int t_d;
    int base;
    bit ir;
    bit dr;
    bit keep_d;
    rst = 0; i_read = 0; i_addr = '0; i_cancel = 0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_rdata = '0; mem_resp = 0;

    tick(); rst = 1;
    tick(); mon = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", 32'(mem_wmask), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_resps", 32'({i_resp, d_resp}), 0);

    // Fetch only, memory latency 3
    lat = 3;
    tick(); i_read = 1; i_addr = 32'h60;
    @(negedge clk);
    chk("t1_no_grant_yet", 32'(mem_read), 0);
    @(negedge clk);
    chk("t1_mem_read", 32'(mem_read), 1);
    chk("t1_mem_addr", mem_addr, 32'h60);
    base = ir_cnt;
    wait_sig(0, 10, "t1_resp", n);
    chk("t1_resp_lat", 32'(n), 3);
    chk("t1_rdata", i_rdata, 32'h13);
    tick(); i_read = 0;
    @(negedge clk);
    chk("t1_idle", 32'(mem_read), 0);
    @(negedge clk);
    chk("t1_one_resp", 32'(ir_cnt - base), 1);

    // Simultaneous requests
    lat = 1;
    tick();
    g_addr.delete(); g_cyc.delete();
    i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h1000;
    @(negedge clk);
    wait_sig(1, 20, "t2_dresp", n);
    t_d = cyc;
    tick(); d_read = 0;
    @(negedge clk);
    wait_sig(0, 20, "t2_iresp", n);
    tick(); i_read = 0;
    @(negedge clk);
    chk("t2_ngrants", 32'(g_addr.size()), 2);
    chk("t2_first_data", g_addr[0], 32'h1000);
    chk("t2_then_fetch", g_addr[1], 32'h100);
    chk("t2_gap", 32'(g_cyc[1] - t_d), 2);

    // Starvation: both held continuously
    lat = 0;
    tick();
    g_addr.delete(); g_cyc.delete();
    i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
    repeat (26) @(negedge clk);
    tick(); i_read = 0; d_read = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t3_grant%0d", k), g_addr[k],
          (k % (LIMIT + 1) == LIMIT) ? 32'h100 : 32'h200);

    // Store with inputs changing while busy
    lat = 3;
    tick();
    d_write = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
    base = dr_cnt;
    @(negedge clk);
    wait_sig(3, 5, "t4_grant", n);
    chk("t4_mem_read", 32'(mem_read), 0);
    chk("t4_mem_addr", mem_addr, 32'h2004);
    tick(); d_addr = '0; d_wdata = '0; d_wmask = 4'hC;
    @(negedge clk);
    n = 0;
    while (!d_resp && n < 10) begin
      chk("t4_hold_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t4_hold_wmask", 32'(mem_wmask), 32'h3);
      @(negedge clk);
      n++;
    end
    chk("t4_dresp", 32'(d_resp), 1);
    chk("t4_wdata_at_resp", mem_wdata, 32'hDEADBEEF);
    tick(); d_write = 0;
    repeat (2) @(negedge clk);
    chk("t4_one_resp", 32'(dr_cnt - base), 1);
    chk("t4_idle", 32'(mem_write), 0);

    // Cancel an in-flight fetch
    lat = 2;
    tick(); i_read = 1; i_addr = 32'h40;
    base = ir_cnt;
    @(negedge clk);
    wait_sig(2, 5, "t5_grant", n);
    tick(); i_cancel = 1; i_read = 0;
    tick(); i_cancel = 0;
    @(negedge clk);
    wait_sig(4, 10, "t5_drain", n);
    @(negedge clk);
    chk("t5_no_iresp", 32'(ir_cnt - base), 0);
    chk("t5_rdata_held", i_rdata, mem_data(32'h100));
    tick(); i_read = 1; i_addr = 32'h80;
    @(negedge clk);
    wait_sig(2, 5, "t5_grant2", n);
    chk("t5_addr2", mem_addr, 32'h80);
    wait_sig(0, 10, "t5_resp2", n);
    chk("t5_rdata2", i_rdata, mem_data(32'h80));
    tick(); i_read = 0;

    // Reset in the middle of a data read
    lat = 1;
    tick(); d_read = 1; d_addr = 32'h300;
    base = dr_cnt;
    @(negedge clk);
    wait_sig(2, 5, "t6_grant", n);
    tick(); rst = 1;
    tick(); rst = 0; d_read = 0;
    @(negedge clk);
    chk("t6_mem_read", 32'(mem_read), 0);
    chk("t6_mem_write", 32'(mem_write), 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wmask", 32'(mem_wmask), 0);
    @(negedge clk);
    chk("t6_no_dresp", 32'(dr_cnt - base), 0);
    tick(); i_read = 1; i_addr = 32'h60;
    @(negedge clk);
    wait_sig(0, 10, "t6_fetch_resp", n);
    chk("t6_fetch_rdata", i_rdata, 32'h13);
    tick(); i_read = 0;
    @(negedge clk);

    // Random traffic
    spur_en = 1;
    keep_d = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ir = i_resp;
      dr = d_resp;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      i_cancel = ($urandom_range(0, 15) == 0);
      if (i_cancel) begin
        i_read = 1'($urandom_range(0, 1));
      end else if (ir) begin
        i_read = 0;
      end else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1;
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (dr && !keep_d) begin
        d_read = 0;
        d_write = 0;
      end else if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1;
        else d_read = 1;
        d_addr = 32'($urandom_range(0, 1023)) << 2;
        keep_d = ($urandom_range(0, 2) == 0);
      end
      if (d_read || d_write) begin
        d_wdata = $urandom;
        d_wmask = 4'($urandom_range(0, 15));
      end
    end
    tick();
    rst = 0; i_read = 0; i_cancel = 0; d_read = 0; d_write = 0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
